// File: rtl/qr_reconstruct.sv
// qr_reconstruct: rebuilds A = Q*R one column at a time with M parallel MAC lanes.
// Signed fixed point, 32 bits with FRAC fractional bits. Only the upper triangle of R is read.
// Optional feature macro QR_RECON_SAT_EN: saturate on narrowing and raise the sticky ovf flag;
// when undefined, results wrap to the low 32 bits and ovf is tied low.
module qr_reconstruct #(
  parameter int M    = 3,
  parameter int N    = 3,
  parameter int FRAC = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [0:M-1][0:N-1][31:0] q_in,
  input  logic [0:N-1][0:N-1][31:0] r_in,
  output logic [0:M-1][0:N-1][31:0] a_out,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf
);

  localparam int            IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, ACC, STORE, DONE} state_t;

  state_t                    state, state_next;
  logic                      load, acc_en, store_en;
  logic [IW-1:0]             k, i;
  logic [0:M-1][0:N-1][31:0] q_reg;
  logic [0:N-1][0:N-1][31:0] r_reg;
  logic signed [63:0]        acc  [M];
  logic signed [63:0]        term [M];
  logic signed [63:0]        r_ext;
  logic [31:0]               narrow [M];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_next = state;
    load       = 1'b0;
    acc_en     = 1'b0;
    store_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        acc_en = 1'b1;
        if (i == k) state_next = STORE;
      end
      STORE: begin
        store_en   = 1'b1;
        state_next = (k == LAST) ? DONE : ACC;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Per-lane product Q[j][i]*R[i][k], full 64-bit signed, floored back to FRAC bits
  always_comb begin
    r_ext = 64'($signed(r_reg[i][k]));
    for (int unsigned j = 0; j < M; j++) begin
      term[j] = (64'($signed(q_reg[j][i])) * r_ext) >>> FRAC;
    end
  end

`ifdef QR_RECON_SAT_EN
  logic col_ovf;

  // Narrow each accumulator to 32 bits, clamping out-of-range values
  always_comb begin
    col_ovf = 1'b0;
    for (int unsigned j = 0; j < M; j++) begin
      if (acc[j] > 64'sh0000_0000_7FFF_FFFF) begin
        narrow[j] = 32'h7FFF_FFFF;
        col_ovf   = 1'b1;
      end else if (acc[j] < 64'shFFFF_FFFF_8000_0000) begin
        narrow[j] = 32'h8000_0000;
        col_ovf   = 1'b1;
      end else begin
        narrow[j] = acc[j][31:0];
      end
    end
  end

  // Sticky overflow: cleared by an accepted start, set by any clamped column
  always_ff @(posedge clk) begin
    if (reset)                    ovf <= 1'b0;
    else if (load)                ovf <= 1'b0;
    else if (store_en && col_ovf) ovf <= 1'b1;
  end
`else
  // Narrow each accumulator to 32 bits by keeping the low word
  always_comb begin
    for (int unsigned j = 0; j < M; j++) begin
      narrow[j] = acc[j][31:0];
    end
  end

  assign ovf = 1'b0;
`endif

  // Snapshot, accumulate along the column, and write finished columns into a_out
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
      r_reg <= '0;
      k     <= '0;
      i     <= '0;
      a_out <= '0;
      for (int unsigned j = 0; j < M; j++) acc[j] <= '0;
    end else begin
      if (load) begin
        q_reg <= q_in;
        r_reg <= r_in;
        k     <= '0;
        i     <= '0;
        for (int unsigned j = 0; j < M; j++) acc[j] <= '0;
      end
      if (acc_en) begin
        for (int unsigned j = 0; j < M; j++) acc[j] <= acc[j] + term[j];
        if (i != k) i <= i + 1'b1;
      end
      if (store_en) begin
        for (int unsigned j = 0; j < M; j++) a_out[j][k] <= narrow[j];
        if (k != LAST) begin
          k <= k + 1'b1;
          i <= '0;
          for (int unsigned j = 0; j < M; j++) acc[j] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_qr_reconstruct.sv
// Self-checking bench for qr_reconstruct (M=N=3): a timeline model of A = Q*R checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_qr_reconstruct;

  localparam int M     = 3;
  localparam int N     = 3;
  localparam int FRAC  = 15;
  localparam int TOTAL = N * (N + 1) / 2 + N + 1;

  logic clk = 1'b0;
  logic reset, start;
  logic [0:M-1][0:N-1][31:0] q_in, r_in, a_out;
  logic busy, done, ovf;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  qr_reconstruct #(.M(M), .N(N), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .start(start), .q_in(q_in), .r_in(r_in),
    .a_out(a_out), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [0:M-1][0:N-1][31:0] m_q, m_r, m_res, exp_a;
  bit m_ovc [N];
  bit m_active = 1'b0;
  int m_t      = 0;
  bit exp_ovf  = 1'b0;

  function automatic logic [31:0] narrow64(input longint v, output bit o);
    o = 1'b0;
`ifdef QR_RECON_SAT_EN
    if (v > longint'(2147483647)) begin o = 1'b1; return 32'h7FFF_FFFF; end
    if (v < -longint'(2147483647) - 1) begin o = 1'b1; return 32'h8000_0000; end
`endif
    return 32'(v);
  endfunction

  // Full product A[j][k] = sum over i<=k of floor(Q[j][i]*R[i][k] / 2^FRAC)
  task automatic model_compute();
    longint s;
    bit o;
    for (int k = 0; k < N; k++) begin
      m_ovc[k] = 1'b0;
      for (int j = 0; j < M; j++) begin
        s = 0;
        for (int i = 0; i <= k; i++)
          s += (longint'($signed(m_q[j][i])) * longint'($signed(m_r[i][k]))) >>> FRAC;
        m_res[j][k] = narrow64(s, o);
        if (o) m_ovc[k] = 1'b1;
      end
    end
  endtask

  // Column k is complete after all ACC cycles of columns 0..k plus k+1 STORE cycles
  function automatic int store_edge(input int k);
    return (k + 1) * (k + 2) / 2 + k + 1;
  endfunction

  // Model timeline advanced on each clock edge
  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_t      = 0;
      exp_a    = '0;
      exp_ovf  = 1'b0;
    end else if (!m_active) begin
      if (start === 1'b1) begin
        m_q = q_in;
        m_r = r_in;
        model_compute();
        m_active = 1'b1;
        m_t      = 0;
        exp_ovf  = 1'b0;
      end
    end else begin
      m_t++;
      for (int k = 0; k < N; k++) begin
        if (m_t == store_edge(k)) begin
          for (int j = 0; j < M; j++) exp_a[j][k] = m_res[j][k];
          if (m_ovc[k]) exp_ovf = 1'b1;
        end
      end
      if (m_t == TOTAL) m_active = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_active);
      check("done", done, m_active && (m_t == TOTAL - 1));
      check("ovf", ovf, exp_ovf);
      check("a_out", a_out, exp_a);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  // Index c counts the value present at edge c, with the accepted start as edge 0
  task automatic wait_done(input int c0, output int at, output int bc);
    at = -1;
    bc = 0;
    for (int c = c0; c < c0 + 40; c++) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
      if (done === 1'b1) begin at = c; break; end
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
  endtask

  task automatic set_ident_q();
    for (int j = 0; j < M; j++)
      for (int i = 0; i < N; i++)
        q_in[j][i] = (i == j) ? 32'h0000_8000 : 32'h0;
  endtask

  function automatic logic [31:0] fx(input real x);
    return 32'($rtoi(x * 32768.0 + ((x < 0.0) ? -0.5 : 0.5)));
  endfunction

  logic [0:M-1][0:N-1][31:0] r1, r2;
  int at, bc, nd, d;
  real av [3][3];
  real qv [3][3];
  real rv [3][3];
  real u  [3];
  real s;
  int a_fx [3][3];

  initial begin
    reset = 1'b1;
    start = 1'b0;
    q_in  = '0;
    r_in  = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;

    // Reset values
    @(negedge clk);
    check("reset_a_out", a_out, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ovf", ovf, 1'b0);

    // Scenario 1: identity Q reproduces R
    r1 = '0;
    r1[0][0] = 32'h0000_8000; r1[0][1] = 32'h0001_0000; r1[0][2] = 32'h0001_8000;
    r1[1][1] = 32'h0002_0000; r1[1][2] = 32'h0002_8000;
    r1[2][2] = 32'h0003_0000;
    set_ident_q();
    r_in = r1;
    do_start();
    wait_done(1, at, bc);
    check("s1_done_edge", at, 10);
    check("s1_busy_cycles", bc, 10);
    @(posedge clk); #2;
    check("s1_a_out", a_out, r1);

    // Scenario 2: lower-triangle garbage and inputs changed mid-run have no effect
    r2 = r1;
    r2[1][0] = 32'h7FFF_FFFF; r2[2][0] = 32'h7FFF_FFFF; r2[2][1] = 32'h7FFF_FFFF;
    set_ident_q();
    r_in = r2;
    do_start();
    @(posedge clk); #2;
    @(posedge clk); #2;
    q_in = {9{32'h1234_5678}};
    r_in = {9{32'hDEAD_BEEF}};
    wait_done(3, at, bc);
    check("s2_done_edge", at, 10);
    @(posedge clk); #2;
    check("s2_a_out", a_out, r1);

    // Scenario 3: -0.5 LSB floors to -1 LSB
    set_ident_q();
    q_in[0][0] = 32'hFFFF_FFFF;
    r_in = '0;
    r_in[0][0] = 32'h0000_4000;
    do_start();
    wait_done(1, at, bc);
    @(posedge clk); #2;
    check("s3_a00_floor", a_out[0][0], 32'hFFFF_FFFF);
    check("s3_a10_zero", a_out[1][0], 32'h0);

    // Scenario 4: 2^15 * 2.0 exceeds the signed 32-bit range
    set_ident_q();
    q_in[0][0] = 32'h4000_0000;
    r_in = '0;
    r_in[0][0] = 32'h0001_0000;
    do_start();
    wait_done(1, at, bc);
    @(posedge clk); #2;
`ifdef QR_RECON_SAT_EN
    check("s4_a00_sat", a_out[0][0], 32'h7FFF_FFFF);
    check("s4_ovf", ovf, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("s4_ovf_held", ovf, 1'b1);
`else
    check("s4_a00_wrap", a_out[0][0], 32'h8000_0000);
    check("s4_ovf", ovf, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("s4_ovf_held", ovf, 1'b0);
`endif

    // Scenario 5a: reset at edge 4 abandons the run without a done pulse
    set_ident_q();
    r_in = r1;
    do_start();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("s5_reset_a_out", a_out, '0);
    check("s5_reset_busy", busy, 1'b0);
    count_done(15, nd);
    check("s5_reset_no_done", nd, 0);

    // Scenario 5b: start pulsed while busy does not launch a second run
    set_ident_q();
    r_in = r1;
    do_start();
    @(posedge clk); #2;
    start = 1'b1;
    q_in  = {9{32'h0001_0000}};
    @(posedge clk); #2;
    start = 1'b0;
    count_done(30, nd);
    check("s5_single_done", nd, 1);
    check("s5_a_out", a_out, r1);

    // Scenario 6: round trip through a Gram-Schmidt factorization
    a_fx = '{'{32'h18000, 32'h8000, 0}, '{32'h8000, 32'h10000, 32'h8000}, '{0, 32'h8000, 32'h18000}};
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < 3; k++) begin
        av[j][k] = real'(a_fx[j][k]) / 32768.0;
        rv[j][k] = 0.0;
      end
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) u[j] = av[j][k];
      for (int i = 0; i < k; i++) begin
        s = 0.0;
        for (int j = 0; j < 3; j++) s += qv[j][i] * av[j][k];
        rv[i][k] = s;
        for (int j = 0; j < 3; j++) u[j] -= s * qv[j][i];
      end
      s = 0.0;
      for (int j = 0; j < 3; j++) s += u[j] * u[j];
      rv[k][k] = $sqrt(s);
      for (int j = 0; j < 3; j++) qv[j][k] = u[j] / rv[k][k];
    end
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < 3; k++) begin
        q_in[j][k] = fx(qv[j][k]);
        r_in[j][k] = fx(rv[j][k]);
      end
    do_start();
    wait_done(1, at, bc);
    check("s6_done_edge", at, 10);
    @(posedge clk); #2;
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < 3; k++) begin
        d = $signed(a_out[j][k]) - a_fx[j][k];
        n_cmp++;
        if (d > 64 || d < -64) begin
          n_bad++;
          $display("FAIL s6_roundtrip[%0d][%0d]: got %0h required %0h +/-64", j, k, a_out[j][k], a_fx[j][k]);
        end
      end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qr_reconstruct.md
# qr_reconstruct

- Rebuilds a matrix from its QR factors: A = Q·R, with Q (M×N) and R (N×N, upper triangular).
- Completes the round trip of the Gram-Schmidt factorization block. It is used to self-check factorizations in simulation and to reconstruct A downstream in the linear-algebra datapath.
- Uses the same signed fixed-point format as the factorization block: 32 bits, 15 fractional bits (1.0 = 32'h0000_8000).
- Computes one column of A at a time with M parallel multiply-accumulate lanes. It reads only the upper triangle of R.

## Interface
Parameters:
- M, 3, number of rows of Q and A
- N, 3, number of columns of Q and A; R is N×N
- FRAC, 15, fractional bits of the fixed-point format

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  request a reconstruction; sampled only in IDLE
- q_in  in  [0:M-1][0:N-1][31:0]  Q matrix; captured on the accepted start edge
- r_in  in  [0:N-1][0:N-1][31:0]  R matrix; captured on the accepted start edge; entries with row > column are ignored
- a_out  out  [0:M-1][0:N-1][31:0]  reconstructed A
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; a_out is complete
- ovf  out  1  sticky overflow flag, cleared on an accepted start

## Operation
States:
- IDLE: on start, snapshot q_in and r_in into internal registers, then set k=0, i=0, clear the accumulators, and go to ACC. Otherwise stay in IDLE.
- ACC: each lane j adds (Q[j][i]·R[i][k]) >>> FRAC to acc[j].
  - If i==k, go to STORE; otherwise i++.
- STORE: write acc[j] into a_out[j][k] for every j.
  - If k==N-1, go to DONE.
  - Otherwise k++, i=0, clear the accumulators, and go to ACC.
- DONE: assert done, then go to IDLE.

Arithmetic:
- Each product is a full 64-bit signed multiply.
- The shift is arithmetic and truncates toward −∞.
- Accumulation is 64-bit signed.
- On STORE, the 64-bit accumulator is narrowed to 32 bits; see Configuration.

Boundary conditions:
- R[i][k] with i>k is never read. Garbage in the lower triangle has no effect.
- start while busy is ignored. The snapshot prevents input changes mid-run from affecting the result.
- start arriving in the DONE cycle is ignored. It is accepted from the following IDLE cycle.
- Reset at any point: state=IDLE, and a_out, ovf, done and busy all go to 0. Any in-flight operation is discarded without a done pulse.
- N=1 degenerates to a single ACC, STORE and DONE sequence.

## Timing
Reset values: a_out all 0, busy 0, done 0, ovf 0.

Accepted start edge = edge 0.
- ACC cycles: N(N+1)/2.
- STORE cycles: N.
- done is high for exactly one cycle, starting at edge N(N+1)/2 + N + 1. For N=3 that is edge 10.
- busy rises at edge 1 and falls at the same edge as done.

Column k of a_out updates at the edge that ends its STORE cycle. a_out holds its value between runs and is overwritten column by column during the next run.

## Configuration
Macro: QR_RECON_SAT_EN.

Defined:
- STORE saturates the accumulator to 32'h7FFF_FFFF or 32'h8000_0000 when it lies outside the signed 32-bit range.
- ovf is set and stays set until the next accepted start.

Undefined:
- STORE keeps the low 32 bits, so out-of-range results wrap.
- ovf is tied to 0.

## Test plan
All scenarios use M=N=3.

1. Identity reconstruction:
   - Stimulus: Q=I (0x8000 on the diagonal); R = [[0x8000,0x10000,0x18000],[0,0x20000,0x28000],[0,0,0x30000]].
   - Response: a_out equals R; done pulses exactly at edge 10; busy spans edges 1–10.
2. Lower-triangle immunity:
   - Stimulus: same as scenario 1, but R's lower triangle is set to 0x7FFF_FFFF, and q_in/r_in are changed at edge 3.
   - Response: identical a_out to scenario 1.
3. Truncation:
   - Stimulus: Q=I except Q[0][0]=32'hFFFF_FFFF; R[0][0]=0x4000.
   - Response: a_out[0][0] = 32'hFFFF_FFFF (−0.5 LSB floors to −1 LSB); a_out[1][0] = 0.
4. Overflow:
   - Stimulus: Q[0][0]=0x4000_0000; R[0][0]=0x10000.
   - Response with QR_RECON_SAT_EN: a_out[0][0]=0x7FFF_FFFF and ovf=1, held until the next start.
   - Response without it: a_out[0][0]=0x8000_0000 and ovf=0.
5. Reset and busy behaviour:
   - Stimulus: start, then reset asserted at edge 4; separately, start pulsed while busy.
   - Response: after reset, a_out=0, busy=0, and no done pulse. The start during busy produces no second run.
6. Round trip:
   - Stimulus: feed the factorization block's Q and R outputs for a full-rank A = [[0x18000,0x8000,0],[0x8000,0x10000,0x8000],[0,0x8000,0x18000]].
   - Response: every a_out entry is within ±64 LSB of A.
